// File: rtl/mac_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mac_feeder
//  Description : Walks a latched presynaptic spike vector in 4-spike groups,
//                reads the matching 128-bit weight word per issued group and
//                presents spike_in/weight to the 4-lane spiking MAC with a
//                valid/last tag two cycles after the read.
//                Optional macro MAC_FEEDER_ZERO_SKIP_EN: skip all-zero groups
//                and stop scanning as soon as no spikes remain.
//  Revision    : 1.0  initial release
// ============================================================================
module mac_feeder #(
    parameter int N_INPUTS = 16,
    parameter int ADDR_W   = 2,
    parameter int CNT_W    = 3
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                start,
    input  logic [N_INPUTS-1:0] spike_vec,
    output logic                busy,
    output logic                done,
    output logic                wmem_rd_en,
    output logic [ADDR_W-1:0]   wmem_addr,
    input  logic [127:0]        wmem_rdata,
    output logic [3:0]          spike_in,
    output logic [127:0]        weight,
    output logic                grp_valid,
    output logic                grp_last,
    output logic [CNT_W-1:0]    grp_count
);

    localparam int                c_NG     = N_INPUTS / 4;
    localparam logic [ADDR_W-1:0] c_LAST_G = ADDR_W'(c_NG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_INPUTS-1:0]   r_rem;
    logic [N_INPUTS-1:0]   w_rem_clr;
    logic [ADDR_W-1:0]     w_g;
    logic [3:0]            w_grp_spk;
    logic [CNT_W-1:0]      r_grp_count;
    logic                  r_drain_cnt;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last;
    logic                  w_drain_done;

    // Read-side pipeline: stage 1 waits for the memory, stage 2 is the beat
    logic                  r_p1_valid;
    logic [3:0]            r_p1_spike;
    logic                  r_p1_last;
    logic                  r_valid;
    logic [3:0]            r_spike;
    logic                  r_last;
    logic [127:0]          r_weight;

`ifdef MAC_FEEDER_ZERO_SKIP_EN
    logic                  w_any;

    // Next group to issue is the lowest group that still holds a spike
    always_comb begin
        w_g = '0;
        for (int i = c_NG - 1; i >= 0; i--) begin
            if (r_rem[4*i +: 4] != 4'b0000) begin
                w_g = ADDR_W'(i);
            end
        end
    end

    // Any spikes left to feed
    always_comb begin
        w_any = |r_rem;
    end
`else
    logic [ADDR_W-1:0]     r_g;

    // Sequential group index, every group is issued in order
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_g <= '0;
        end else if (w_accept) begin
            r_g <= '0;
        end else if (w_issue) begin
            r_g <= r_g + ADDR_W'(1);
        end
    end

    assign w_g = r_g;
`endif

    // Select the current group's spikes and form rem with that group cleared
    always_comb begin
        w_grp_spk = 4'b0000;
        w_rem_clr = r_rem;
        for (int i = 0; i < c_NG; i++) begin
            if (ADDR_W'(i) == w_g) begin
                w_grp_spk           = r_rem[4*i +: 4];
                w_rem_clr[4*i +: 4] = 4'b0000;
            end
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle issue decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_last       = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
`ifdef MAC_FEEDER_ZERO_SKIP_EN
                if (!w_any) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_issue = 1'b1;
                    w_last  = (w_rem_clr == '0);
                    if (w_last) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
`else
                w_issue = 1'b1;
                w_last  = (r_g == c_LAST_G);
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
                if (r_drain_cnt) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Remaining vector, issued-group count, drain timer and done pulse
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rem       <= '0;
            r_grp_count <= '0;
            r_drain_cnt <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rem       <= spike_vec;
                r_grp_count <= '0;
            end else if (w_issue) begin
                r_rem       <= w_rem_clr;
                r_grp_count <= r_grp_count + CNT_W'(1);
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
            r_done      <= w_drain_done;
        end
    end

    // Two-stage beat pipeline aligning spikes with the returned weight word
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_p1_valid <= 1'b0;
            r_p1_spike <= 4'b0000;
            r_p1_last  <= 1'b0;
            r_valid    <= 1'b0;
            r_spike    <= 4'b0000;
            r_last     <= 1'b0;
            r_weight   <= '0;
        end else begin
            r_p1_valid <= w_issue;
            r_p1_spike <= w_issue ? w_grp_spk : 4'b0000;
            r_p1_last  <= w_last;
            r_valid    <= r_p1_valid;
            r_spike    <= r_p1_spike;
            r_last     <= r_p1_last;
            r_weight   <= r_p1_valid ? wmem_rdata : '0;
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign wmem_rd_en = w_issue;
    assign wmem_addr  = w_issue ? w_g : '0;
    assign spike_in   = r_spike;
    assign weight     = r_weight;
    assign grp_valid  = r_valid;
    assign grp_last   = r_last;
    assign grp_count  = r_grp_count;

endmodule
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_feeder
//  Description : Directed self-checking bench for mac_feeder (N_INPUTS=16).
//                Expectations follow MAC_FEEDER_ZERO_SKIP_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mac_feeder;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   spike_vec = 16'h0000;
    logic          busy;
    logic          done;
    logic          wmem_rd_en;
    logic [1:0]    wmem_addr;
    logic [127:0]  wmem_rdata = '0;
    logic [3:0]    spike_in;
    logic [127:0]  weight;
    logic          grp_valid;
    logic          grp_last;
    logic [2:0]    grp_count;

    logic [127:0]  mem [4];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_bad = 0;
    int            inv_bad = 0;

    int            rd_addr_q[$];
    int            rd_cyc_q[$];
    int            bt_cyc_q[$];
    logic [3:0]    bt_spk_q[$];
    logic [127:0]  bt_w_q[$];
    logic          bt_last_q[$];

    mac_feeder #(
        .N_INPUTS (16),
        .ADDR_W   (2),
        .CNT_W    (3)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .start      (start),
        .spike_vec  (spike_vec),
        .busy       (busy),
        .done       (done),
        .wmem_rd_en (wmem_rd_en),
        .wmem_addr  (wmem_addr),
        .wmem_rdata (wmem_rdata),
        .spike_in   (spike_in),
        .weight     (weight),
        .grp_valid  (grp_valid),
        .grp_last   (grp_last),
        .grp_count  (grp_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Weight memory: one-cycle read latency, junk when not read
    always @(posedge CLK) wmem_rdata <= wmem_rd_en ? mem[wmem_addr] : {4{32'hDEAD_BEEF}};

    // Record reads and beats; outside beats the MAC must see nothing
    always @(negedge CLK) begin
        if (wmem_rd_en) begin
            rd_addr_q.push_back(int'(wmem_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (grp_valid) begin
            bt_cyc_q.push_back(cyc);
            bt_spk_q.push_back(spike_in);
            bt_w_q.push_back(weight);
            bt_last_q.push_back(grp_last);
        end else if (spike_in != 4'h0 || weight != '0 || grp_last) begin
            inv_bad++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_q();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        bt_cyc_q.delete();
        bt_spk_q.delete();
        bt_w_q.delete();
        bt_last_q.delete();
    endtask

    // Present start for one edge; a = first SCAN cycle
    task automatic start_op(input logic [15:0] vec, output int a);
        start     = 1'b1;
        spike_vec = vec;
        tick();
        start     = 1'b0;
        spike_vec = 16'h5A5A;
        a         = cyc;
    endtask

    // Bounded wait for the done pulse; d = done cycle
    task automatic wait_done(input string tag, output int d);
        int k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        if (!done) chk({tag, ".timeout"}, 128'd0, 128'd1);
        chk({tag, ".busy_at_done"}, busy, 1'b0);
        d = cyc;
    endtask

    // Compare recorded reads/beats with n expected groups (4-bit packed lists)
    task automatic check_op(input string tag, input int a, input int d, input int n,
                            input logic [15:0] addrs, input logic [15:0] spks,
                            input int done_off, input logic [2:0] cnt);
        logic [1:0] ea;
        chk({tag, ".n_reads"}, rd_addr_q.size(), n);
        chk({tag, ".n_beats"}, bt_cyc_q.size(), n);
        for (int i = 0; i < n; i++) begin
            ea = addrs[4*i +: 2];
            if (i < rd_addr_q.size()) begin
                chk($sformatf("%s.addr%0d", tag, i), rd_addr_q[i], ea);
                chk($sformatf("%s.rdcyc%0d", tag, i), rd_cyc_q[i], a + i);
            end
            if (i < bt_cyc_q.size()) begin
                chk($sformatf("%s.spk%0d", tag, i), bt_spk_q[i], spks[4*i +: 4]);
                chk($sformatf("%s.wgt%0d", tag, i), bt_w_q[i], mem[ea]);
                chk($sformatf("%s.bcyc%0d", tag, i), bt_cyc_q[i], a + i + 2);
                chk($sformatf("%s.last%0d", tag, i), bt_last_q[i], (i == n - 1));
            end
        end
        chk({tag, ".done_at"}, d - a, done_off);
        chk({tag, ".count"}, grp_count, cnt);
        clear_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int d;
        int nd;

        mem[0] = 128'h3F80_0000_3F80_0000_3F80_0000_3F80_0000;
        mem[1] = 128'h4000_0000_3F80_0000_4040_0000_4080_0000;
        mem[2] = 128'h4100_0000_4110_0000_4120_0000_4130_0000;
        mem[3] = 128'hC000_0000_C040_0000_C080_0000_C0A0_0000;

        // Reset state
        tick();
        tick();
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.rd_en", wmem_rd_en, 1'b0);
        chk("rst.addr", wmem_addr, 2'd0);
        chk("rst.valid", grp_valid, 1'b0);
        chk("rst.last", grp_last, 1'b0);
        chk("rst.spike", spike_in, 4'h0);
        chk("rst.weight", weight, 128'd0);
        chk("rst.count", grp_count, 3'd0);
        RESET_N = 1'b1;
        tick();

        // Reset asserted mid-SCAN: outputs clear at once, no done follows
        start_op(16'hFFFF, a);
        tick();
        chk("midrst.busy_pre", busy, 1'b1);
        RESET_N = 1'b0;
        #1;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.rd_en", wmem_rd_en, 1'b0);
        chk("midrst.valid", grp_valid, 1'b0);
        chk("midrst.count", grp_count, 3'd0);
        tick();
        tick();
        RESET_N = 1'b1;
        nd = 0;
        repeat (8) begin
            tick();
            if (done || grp_valid) nd++;
        end
        chk("midrst.no_done_or_beat", nd, 0);
        clear_q();

        // Mixed vector with an empty group in the middle
        start_op(16'h0F01, a);
        chk("op1.busy", busy, 1'b1);
        wait_done("op1", d);
`ifdef MAC_FEEDER_ZERO_SKIP_EN
        check_op("op1", a, d, 2, 16'h0020, 16'h00F1, 4, 3'd2);
`else
        check_op("op1", a, d, 4, 16'h3210, 16'h0F01, 6, 3'd4);
`endif

        // A start pulse with another vector while busy is ignored
        start_op(16'h0F01, a);
        start     = 1'b1;
        spike_vec = 16'hF0F0;
        tick();
        start     = 1'b0;
        wait_done("busy_ign", d);
`ifdef MAC_FEEDER_ZERO_SKIP_EN
        check_op("busy_ign", a, d, 2, 16'h0020, 16'h00F1, 4, 3'd2);
`else
        check_op("busy_ign", a, d, 4, 16'h3210, 16'h0F01, 6, 3'd4);
`endif

        // Start accepted in the done cycle (back-to-back)
        start_op(16'h8000, a);
        chk("b2b.start", a, d + 1);
        wait_done("b2b", d);
`ifdef MAC_FEEDER_ZERO_SKIP_EN
        check_op("b2b", a, d, 1, 16'h0003, 16'h0008, 3, 3'd1);
`else
        check_op("b2b", a, d, 4, 16'h3210, 16'h8000, 6, 3'd4);
`endif

        // grp_count holds after done
        repeat (3) tick();
`ifdef MAC_FEEDER_ZERO_SKIP_EN
        chk("hold.count", grp_count, 3'd1);
`else
        chk("hold.count", grp_count, 3'd4);
`endif
        chk("hold.idle", busy, 1'b0);

        // All-zero vector
        start_op(16'h0000, a);
        wait_done("zero", d);
`ifdef MAC_FEEDER_ZERO_SKIP_EN
        check_op("zero", a, d, 0, 16'h0000, 16'h0000, 3, 3'd0);
`else
        check_op("zero", a, d, 4, 16'h3210, 16'h0000, 6, 3'd4);
`endif

        tick();
        chk("idle_outputs_zero", inv_bad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
